// File: rtl/layer2_feeder.sv
// -----------------------------------------------------------------------------
// layer2_feeder
//
// Streaming source for the layer-2 neuron bank. A single-cycle in_valid strobe
// from layer 1 captures the N_IN ReLU results. The block then replays them onto
// a shared signed value bus using the same protocol the layer-1 neurons use.
// First it walks the bias ROM and issues one-hot bias loads. Then it walks the
// weight ROM address and issues accumulate strobes carrying the captured
// ReLU values. Every strobe is delayed by ROM_LAT cycles, so it lines up with
// the registered ROM read data.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous reset, active low (0 = reset)
//   in_valid     : capture strobe from layer 1 (relu_in valid this cycle)
//   relu_in      : packed signed ReLU results, element k at [k*DATA_W +: DATA_W]
//   bias_value   : bias ROM read data (ROM_LAT cycles after bias_addr)
//   bias_addr    : bias ROM address (0 outside the bias phase)
//   neuron1_addr : weight ROM address (0 outside the data phase)
//   bias_load    : one-hot; value_out carries the bias for neuron n
//   acc_en       : value_out carries a ReLU element to accumulate
//   value_out    : signed data bus, 0 when neither bias_load nor acc_en
//   layer_done   : single-cycle pulse at the end of the sequence
//   busy         : high from the cycle after capture through layer_done
//   overrun      : sticky; in_valid seen while busy
// -----------------------------------------------------------------------------
module layer2_feeder #(
  parameter int N_IN    = 10,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [N_IN*DATA_W-1:0]    relu_in,
  input  logic signed [DATA_W-1:0]  bias_value,
  output logic [ADDR_W-1:0]         bias_addr,
  output logic [ADDR_W-1:0]         neuron1_addr,
  output logic [N_IN-1:0]           bias_load,
  output logic                      acc_en,
  output logic signed [DATA_W-1:0]  value_out,
  output logic                      layer_done,
  output logic                      busy,
  output logic                      overrun
);

  // One counter serves every phase. It must reach both N_IN-1 and ROM_LAT-1.
  localparam int CNT_MAX = (N_IN > ROM_LAT) ? N_IN : ROM_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic                      last_in_phase;
  logic                      last_in_drain;

  logic signed [DATA_W-1:0]  cap [N_IN];

  // Stage p0: strobes issued in the same cycle as the ROM address.
  logic [N_IN-1:0]           bias_oh_p0;
  logic                      vld_p0;
  logic signed [DATA_W-1:0]  data_p0;

  // Stages p1..pROM_LAT: entry j holds stage j+1.
  logic [N_IN-1:0]           bias_oh_pn [ROM_LAT];
  logic                      vld_pn     [ROM_LAT];
  logic signed [DATA_W-1:0]  data_pn    [ROM_LAT];

  function automatic logic [N_IN-1:0] onehot(input logic [CNT_W-1:0] idx);
    logic [N_IN-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign cnt_nxt       = cnt + 1'b1;
  assign last_in_phase = (cnt == CNT_W'(N_IN - 1));
  assign last_in_drain = (cnt == CNT_W'(ROM_LAT - 1));

  // ---------------------------------------------------------------------------
  // Sequencer: capture, phase control, ROM addresses and stage-p0 strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bias_addr    <= '0;
      neuron1_addr <= '0;
      bias_oh_p0   <= '0;
      vld_p0       <= 1'b0;
      data_p0      <= '0;
      layer_done   <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int k = 0; k < N_IN; k++) cap[k] <= '0;
    end else begin
      // busy already covers the DONE cycle, so a strobe there also counts.
      if (in_valid && busy) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_IN; k++)
              cap[k] <= relu_in[k*DATA_W +: DATA_W];
            state      <= S_BIAS;
            cnt        <= '0;
            bias_addr  <= '0;
            bias_oh_p0 <= onehot('0);
            busy       <= 1'b1;
          end
        end

        S_BIAS: begin
          if (last_in_phase) begin
            state        <= S_DATA;
            cnt          <= '0;
            bias_addr    <= '0;
            bias_oh_p0   <= '0;
            neuron1_addr <= '0;
            vld_p0       <= 1'b1;
            data_p0      <= cap[0];
          end else begin
            cnt        <= cnt_nxt;
            bias_addr  <= ADDR_W'(cnt_nxt);
            bias_oh_p0 <= onehot(cnt_nxt);
          end
        end

        S_DATA: begin
          if (last_in_phase) begin
            state        <= S_DRAIN;
            cnt          <= '0;
            neuron1_addr <= '0;
            vld_p0       <= 1'b0;
            data_p0      <= '0;
          end else begin
            cnt          <= cnt_nxt;
            neuron1_addr <= ADDR_W'(cnt_nxt);
            data_p0      <= cap[cnt_nxt];
          end
        end

        // Wait for the last accumulate strobe to leave the delay line.
        S_DRAIN: begin
          if (last_in_drain) begin
            state      <= S_DONE;
            cnt        <= '0;
            layer_done <= 1'b1;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          layer_done <= 1'b0;
          busy       <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stages p1..pROM_LAT: delay strobes and ReLU data to meet ROM read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < ROM_LAT; j++) begin
        bias_oh_pn[j] <= '0;
        vld_pn[j]     <= 1'b0;
        data_pn[j]    <= '0;
      end
    end else begin
      bias_oh_pn[0] <= bias_oh_p0;
      vld_pn[0]     <= vld_p0;
      data_pn[0]    <= data_p0;
      for (int j = 1; j < ROM_LAT; j++) begin
        bias_oh_pn[j] <= bias_oh_pn[j-1];
        vld_pn[j]     <= vld_pn[j-1];
        data_pn[j]    <= data_pn[j-1];
      end
    end
  end

  assign bias_load = bias_oh_pn[ROM_LAT-1];
  assign acc_en    = vld_pn[ROM_LAT-1];

  // The bias is taken straight from the ROM port in its aligned cycle.
  // Bias and data phases never overlap in the delay line.
  always_comb begin
    value_out = '0;
    if (|bias_load)
      value_out = bias_value;
    else if (acc_en)
      value_out = data_pn[ROM_LAT-1];
  end

endmodule

// File: doc/layer2_feeder.md
Name: layer2_feeder

Overview:
- Streaming source for the layer-2 neuron bank; the producer-side counterpart to the layer-1 neuron accumulator interface.
- On a layer-1 `valid` strobe, it captures the ten ReLU results.
- It then replays them onto a shared value bus in the same bias-load-then-accumulate protocol the layer-1 neurons consume.
- It drives `neuron1_addr` to the layer-2 weight ROMs and `bias_addr` to the layer-2 bias ROM, with all outputs aligned to the ROMs' read latency.

Parameters:
- N_IN, 10: number of layer-1 results and layer-2 neurons (bias one-hot width).
- DATA_W, 32: signed data width of values, biases and ReLU results.
- ADDR_W, 4: width of `neuron1_addr` and `bias_addr`.
- ROM_LAT, 1: registered read latency of the bias and weight ROMs, in cycles (≥1).

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- rst, input, 1: reset, synchronous, active-low (0 = reset); asserted in reset for at least one clk edge.
- in_valid, input, 1: single-cycle strobe from layer 1; `relu_in` is valid in this cycle.
- relu_in, input, N_IN*DATA_W: packed signed ReLU results; element k is bits [k*DATA_W +: DATA_W].
- bias_value, input, DATA_W: signed bias2 ROM read data.
- bias_addr, output, ADDR_W: bias2 ROM address.
- neuron1_addr, output, ADDR_W: layer-2 weight ROM address (index of the layer-1 result being presented).
- bias_load, output, N_IN: one-hot; bit n high means `value_out` carries the bias for layer-2 neuron n.
- acc_en, output, 1: `value_out` carries a ReLU element to multiply-accumulate with the weight ROM outputs.
- value_out, output, DATA_W: signed layer-2 data bus.
- layer_done, output, 1: single-cycle pulse; layer-2 accumulation is complete.
- busy, output, 1: high from the cycle after capture through the `layer_done` cycle.
- overrun, output, 1: sticky; `in_valid` arrived while busy.

Behaviour:
- Reset (`rst`=0 at an edge): state IDLE. All outputs are 0, including `bias_load`, `value_out`, `overrun` and both addresses. The capture registers are cleared and the delay pipelines flushed. Reset wins over a simultaneous `in_valid`. Reset mid-sequence aborts with no `layer_done`.
- States:
  - IDLE → BIAS on `in_valid`.
  - BIAS: N_IN cycles, then → DATA.
  - DATA: N_IN cycles, then → DRAIN.
  - DRAIN: ROM_LAT cycles, then → DONE.
  - DONE: 1 cycle, then → IDLE.
- Capture: in IDLE, `in_valid`=1 latches all N_IN elements of `relu_in` at that edge. Later changes on `relu_in` have no effect.
- BIAS phase: `bias_addr` = 0, 1, …, N_IN-1 on successive cycles. `bias_load` = one-hot(i) exactly ROM_LAT cycles after `bias_addr`=i, with `value_out` = `bias_value` in the same cycle.
- DATA phase: `neuron1_addr` = 0, 1, …, N_IN-1 on successive cycles. ROM_LAT cycles later, `acc_en`=1 and `value_out` = captured element k, i.e. the ReLU value is delayed to align with the weight ROM data.
- Addresses hold 0 outside their phase.
- `value_out` = 0 whenever `bias_load`=0 and `acc_en`=0. `bias_load` and `acc_en` are never high in the same cycle.
- Timing, ROM_LAT=1, `in_valid` at cycle t:
  - `busy` high t+1..t+22.
  - `bias_addr` 0..9 at t+1..t+10; `bias_load` at t+2..t+11.
  - `neuron1_addr` 0..9 at t+11..t+20; `acc_en` at t+12..t+21.
  - `layer_done` at t+22.
  - Next `in_valid` accepted from t+23.
- General latency: `layer_done` fires 2·N_IN + ROM_LAT + 1 cycles after `in_valid`.
- `in_valid` while `busy`=1 (including the DONE cycle): ignored, no re-capture, `overrun` set to 1 until reset.
- Arithmetic: none beyond counting. Counters are sized to N_IN and wrap to 0 at each phase change. Values pass through bit-exact, sign preserved.

Test Plan:
- Basic sequence: reset, then `in_valid` with `relu_in` = {k*100+5}, `bias_value` ROM model bias[i] = -i-1 → `bias_load` one-hot 1,2,4,…,512 with `value_out` -1..-10 at t+2..t+11; `acc_en` with `value_out` 5, 105, …, 905 at t+12..t+21; `layer_done` at t+22 only.
- Capture isolation: change `relu_in` to all 0xFFFFFFFF at t+1 → streamed values are still 5..905.
- Overrun: second `in_valid` at t+15 and at t+22 (DONE) → sequence unchanged, `overrun`=1 and stays 1. A third `in_valid` at t+23 starts a new sequence.
- Reset mid-op: `rst`=0 at t+13 → next cycle all outputs 0, `busy`=0, no `layer_done`. A fresh `in_valid` then gives the full sequence.
- Negative values: `relu_in` element 3 = 32'sh80000000 → `value_out` exactly 0x80000000 at the `acc_en` cycle for k=3.
- Reset vs strobe: `rst`=0 with `in_valid`=1 in the same cycle → remains IDLE, `busy`=0.
